tx_framer: RTL and testbench
============================

// Module: tx_framer
// PURPOSE
//  Upstream feeder for the 8b/10b TX encoder. Buffers user bytes and K-chars in a small FIFO.
//  Emits one {TxParallel_8, TxDataK} per BitCLK_10 cycle. Inserts K28.5 commas in three
//  cases: after reset, when idle, and at a fixed period during long data runs. Outputs
//  drive the encoder inputs directly, one word per cycle, so the encoder always gets a code.
// PARAMETERS
//  FIFO_DEPTH    8    entries; power of 2, >=2
//  ALIGN_WORDS   16   K28.5 words sent in ALIGN state before data is allowed; >=1
//  COMMA_PERIOD  256  one forced K28.5 per COMMA_PERIOD output words in RUN; >=2
// PORTS
//  BitCLK_10     in   1   word clock; all logic on its rising edge
//  Reset         in   1   asynchronous, active-low reset
//  TxData        in   8   user byte
//  TxDataKIn     in   1   TxData is a control char (K28.y only)
//  TxDataValid   in   1   write request
//  TxDataReady   out  1   FIFO can accept; write occurs when TxDataValid & TxDataReady
//  TxEnable      in   1   1 = drain FIFO; 0 = send idle commas, keep FIFO contents
//  TxRealign     in   1   sync pulse: re-enter ALIGN; FIFO retained
//  TxParallel_8  out  8   to encoder data input (registered)
//  TxDataK       out  1   to encoder K input (registered)
//  TxAligned     out  1   1 while in RUN state
//  KError        out  1   1-cycle pulse: illegal user K-char replaced
//  TxFifoLevel   out  $clog2(FIFO_DEPTH)+1   entries held
// BEHAVIOUR
//  Reset (async, Reset=0), all outputs registered:
//   - TxParallel_8=8'hBC, TxDataK=1 (K28.5).
//   - TxAligned=0, KError=0, TxDataReady=0, TxFifoLevel=0.
//   - FIFO emptied, state=ALIGN, align and comma counters =0.
//  FIFO: 9-bit entries {K,data}, circular pointers wrap at FIFO_DEPTH.
//   - TxDataReady is registered = (next level < FIFO_DEPTH).
//   - Push and pop in the same cycle: level unchanged. When full, no push even if popping.
//   - Pop only sees entries present at the start of the cycle; a word never falls through
//     from push to pop in one cycle.
//   - Latency: word written at edge N appears on TxParallel_8 after edge N+1 at the
//     earliest (empty FIFO, RUN, TxEnable=1, no forced comma).
//  FSM (2 states):
//   - ALIGN: output K28.5 every cycle, no pop. align_cnt counts 0..ALIGN_WORDS-1; the
//     edge at ALIGN_WORDS-1 moves to RUN. TxAligned=0. Pushes still accepted.
//   - RUN: TxAligned=1. Per-cycle output priority:
//      1) comma_cnt==COMMA_PERIOD-1 -> K28.5, no pop, comma_cnt<=0
//      2) TxEnable & level!=0 -> pop, output entry, comma_cnt++
//      3) else -> K28.5 idle, comma_cnt<=0
//   - TxRealign=1 in any state -> ALIGN next cycle, align_cnt<=0, comma_cnt<=0.
//     The output that cycle is still produced by the current state rules.
//  K-char legality: encoder supports only K28.y, so a popped entry with K=1 must have
//   data[4:0]==5'h1C. Otherwise: output 8'hBC/K=1 and KError=1 for that cycle.
//   Comma counting is as for a data word.
//  comma_cnt width $clog2(COMMA_PERIOD); never exceeds COMMA_PERIOD-1.
//  TxEnable and TxRealign are level/pulse inputs sampled each edge, already synchronous.
// TESTING
//  1 Release reset, TxEnable=1, no writes -> 16 cycles BC/K=1 with TxAligned=0, then
//    TxAligned=1 and BC/K=1 continuously; TxDataReady=1 from the 1st edge after reset.
//  2 RUN, TxEnable=1: write 11,22,33 (K=0) on edges N..N+2 -> outputs 11,22,33 K=0
//    after edges N+1..N+3, then BC/K=1; TxFifoLevel peaks at 1.
//  3 TxEnable=0: write 8 bytes -> level=8, TxDataReady=0, 9th write held. Set TxEnable=1
//    -> 8 bytes out in order on consecutive cycles; TxDataReady returns 1.
//  4 COMMA_PERIOD=4, 10 bytes queued, TxEnable=1 -> output pattern D D D BC D D D BC D D D BC
//    (K=1 only on BC); no byte lost or reordered.
//  5 Write {K=1,3C} then {K=1,F7} -> outputs 3C/K=1 with KError=0, then BC/K=1 with
//    KError=1 for exactly one cycle.
//  6 Assert Reset mid-stream with 5 queued -> immediate BC/K=1, TxAligned=0, level=0.
//    After release, full ALIGN sequence repeats and no old bytes emerge.
//    Also: TxRealign pulse in RUN -> 16 BC, FIFO data then resumes intact.

Source files
------------

// File: rtl/tx_framer_if.sv
// Write-side handshake bundle between the user logic and the TX framer.
// The user side drives data, K flag and valid; the framer returns ready.
interface tx_framer_if;
  logic [7:0] TxData;
  logic       TxDataKIn;
  logic       TxDataValid;
  logic       TxDataReady;

  modport master (
    output TxData,
    output TxDataKIn,
    output TxDataValid,
    input  TxDataReady
  );

  modport slave (
    input  TxData,
    input  TxDataKIn,
    input  TxDataValid,
    output TxDataReady
  );
endinterface

// File: rtl/tx_framer.sv
// Byte/K-char framer feeding the 8b/10b encoder: small FIFO, K28.5 alignment
// preamble, idle commas and periodic forced commas during long data runs.
module tx_framer #(
  parameter int unsigned FIFO_DEPTH   = 8,
  parameter int unsigned ALIGN_WORDS  = 16,
  parameter int unsigned COMMA_PERIOD = 256
) (
  input  logic                          BitCLK_10,
  input  logic                          Reset,
  tx_framer_if.slave                    wr,
  input  logic                          TxEnable,
  input  logic                          TxRealign,
  output logic [7:0]                    TxParallel_8,
  output logic                          TxDataK,
  output logic                          TxAligned,
  output logic                          KError,
  output logic [$clog2(FIFO_DEPTH):0]   TxFifoLevel
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;
  localparam int unsigned ALN_W = (ALIGN_WORDS > 1) ? $clog2(ALIGN_WORDS) : 1;
  localparam int unsigned CMA_W = $clog2(COMMA_PERIOD);
  localparam int unsigned ENT_W = 9;
  localparam logic [7:0]  K28_5 = 8'hBC;

  typedef enum logic {
    ST_ALIGN = 1'b0,
    ST_RUN   = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [ALN_W-1:0]   align_q, align_d;
  logic [CMA_W-1:0]   comma_q, comma_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]   level_q, level_d;
  logic               ready_q, ready_d;
  logic [7:0]         data_q, data_d;
  logic               k_q, k_d;
  logic               aligned_q, aligned_d;
  logic               kerr_q, kerr_d;
  logic [ENT_W-1:0]   mem [FIFO_DEPTH];
  logic [ENT_W-1:0]   head_c;
  logic               push_c;
  logic               pop_c;

  assign push_c = wr.TxDataValid & ready_q;
  assign head_c = mem[rd_ptr_q];

  // FIFO storage; contents need no reset since level gates every read
  always_ff @(posedge BitCLK_10) begin
    if (push_c) begin
      mem[wr_ptr_q] <= {wr.TxDataKIn, wr.TxData};
    end
  end

  // State register and all registered outputs
  always_ff @(posedge BitCLK_10 or negedge Reset) begin
    if (!Reset) begin
      state_q   <= ST_ALIGN;
      align_q   <= '0;
      comma_q   <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      ready_q   <= 1'b0;
      data_q    <= K28_5;
      k_q       <= 1'b1;
      aligned_q <= 1'b0;
      kerr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      align_q   <= align_d;
      comma_q   <= comma_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      ready_q   <= ready_d;
      data_q    <= data_d;
      k_q       <= k_d;
      aligned_q <= aligned_d;
      kerr_q    <= kerr_d;
    end
  end

  // Next-state logic; a realign request overrides the ALIGN->RUN exit
  always_comb begin
    state_d = state_q;
    if (TxRealign) begin
      state_d = ST_ALIGN;
    end else if ((state_q == ST_ALIGN) && (align_q == ALN_W'(ALIGN_WORDS - 1))) begin
      state_d = ST_RUN;
    end
  end

  // Output word selection, counters and pop decision
  always_comb begin
    pop_c     = 1'b0;
    data_d    = K28_5;
    k_d       = 1'b1;
    kerr_d    = 1'b0;
    align_d   = align_q;
    comma_d   = comma_q;
    case (state_q)
      ST_ALIGN: begin
        comma_d = '0;
        if (align_q == ALN_W'(ALIGN_WORDS - 1)) begin
          align_d = '0;
        end else begin
          align_d = align_q + ALN_W'(1);
        end
      end
      ST_RUN: begin
        if (comma_q == CMA_W'(COMMA_PERIOD - 1)) begin
          comma_d = '0;
        end else if (TxEnable && (level_q != '0)) begin
          pop_c   = 1'b1;
          comma_d = comma_q + CMA_W'(1);
          // Encoder only knows K28.y; anything else becomes a comma plus an error pulse
          if (head_c[8] && (head_c[4:0] != 5'h1C)) begin
            kerr_d = 1'b1;
          end else begin
            data_d = head_c[7:0];
            k_d    = head_c[8];
          end
        end else begin
          comma_d = '0;
        end
      end
      default: begin
        comma_d = '0;
      end
    endcase
    if (TxRealign) begin
      align_d = '0;
      comma_d = '0;
    end
    aligned_d = (state_d == ST_RUN);
  end

  // FIFO pointer and occupancy bookkeeping
  always_comb begin
    wr_ptr_d = push_c ? (wr_ptr_q + PTR_W'(1)) : wr_ptr_q;
    rd_ptr_d = pop_c  ? (rd_ptr_q + PTR_W'(1)) : rd_ptr_q;
    level_d  = level_q + LVL_W'(push_c) - LVL_W'(pop_c);
    ready_d  = (level_d < LVL_W'(FIFO_DEPTH));
  end

  assign wr.TxDataReady = ready_q;
  assign TxParallel_8   = data_q;
  assign TxDataK        = k_q;
  assign TxAligned      = aligned_q;
  assign KError         = kerr_q;
  assign TxFifoLevel    = level_q;

endmodule

// File: tb/tb_tx_framer.sv
// Self-checking bench for tx_framer: scoreboard of written words against the
// encoder-side stream, plus directed checks of alignment, flow control and commas.
module tb_tx_framer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en, realign, en4;
  logic [7:0] out_d;
  logic       out_k, aligned, kerr;
  logic [3:0] level;
  logic [7:0] o4_d;
  logic       o4_k, o4_al, o4_ke;
  logic [3:0] o4_lv;

  int         n_vec = 0;
  int         n_err = 0;
  logic [9:0] exp_q [$];
  logic [9:0] sb_e;
  bit         mon_en = 1'b0;
  logic [8:0] cap4 [13];

  always #5 clk = ~clk;

  tx_framer_if bus ();
  tx_framer_if bus4 ();

  tx_framer dut (
    .BitCLK_10    (clk),
    .Reset        (rst_n),
    .wr           (bus),
    .TxEnable     (en),
    .TxRealign    (realign),
    .TxParallel_8 (out_d),
    .TxDataK      (out_k),
    .TxAligned    (aligned),
    .KError       (kerr),
    .TxFifoLevel  (level)
  );

  tx_framer #(.COMMA_PERIOD(4)) dut4 (
    .BitCLK_10    (clk),
    .Reset        (rst_n),
    .wr           (bus4),
    .TxEnable     (en4),
    .TxRealign    (1'b0),
    .TxParallel_8 (o4_d),
    .TxDataK      (o4_k),
    .TxAligned    (o4_al),
    .KError       (o4_ke),
    .TxFifoLevel  (o4_lv)
  );

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [9:0] exp_code(input logic k, input logic [7:0] d);
    if (k && (d[4:0] != 5'h1C)) return {1'b1, 1'b1, 8'hBC};
    return {1'b0, k, d};
  endfunction

  task automatic push_word(input logic k, input logic [7:0] d);
    int   n;
    logic acc;
    n   = 0;
    acc = 1'b0;
    bus.TxDataValid = 1'b1;
    bus.TxDataKIn   = k;
    bus.TxData      = d;
    while (!acc && (n < 200)) begin
      acc = bus.TxDataReady;
      tick();
      n++;
    end
    bus.TxDataValid = 1'b0;
    check_eq("push_accept", 16'(acc), 16'd1);
    if (acc) exp_q.push_back(exp_code(k, d));
  endtask

  task automatic push4(input logic [7:0] d);
    int   n;
    logic acc;
    n   = 0;
    acc = 1'b0;
    bus4.TxDataValid = 1'b1;
    bus4.TxDataKIn   = 1'b0;
    bus4.TxData      = d;
    while (!acc && (n < 200)) begin
      acc = bus4.TxDataReady;
      tick();
      n++;
    end
    bus4.TxDataValid = 1'b0;
    check_eq("push4_accept", 16'(acc), 16'd1);
  endtask

  // Every non-idle word on the encoder side must match the oldest written word
  always @(negedge clk) begin
    if (mon_en && !(out_k && (out_d == 8'hBC) && !kerr)) begin
      if (exp_q.size() == 0) begin
        check_eq("sb_unexpected_word", 16'(exp_q.size()), 16'd1);
      end else begin
        sb_e = exp_q.pop_front();
        check_eq("sb_word", 16'({kerr, out_k, out_d}), 16'(sb_e));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic bad;
    int   kcnt;
    int   di;
    rst_n = 1'b0;
    en = 1'b1;
    realign = 1'b0;
    en4 = 1'b0;
    bus.TxDataValid = 1'b0;
    bus.TxDataKIn = 1'b0;
    bus.TxData = 8'h00;
    bus4.TxDataValid = 1'b0;
    bus4.TxDataKIn = 1'b0;
    bus4.TxData = 8'h00;
    repeat (2) tick();

    check_eq("rst_data", 16'(out_d), 16'hBC);
    check_eq("rst_k", 16'(out_k), 16'd1);
    check_eq("rst_aligned", 16'(aligned), 16'd0);
    check_eq("rst_kerr", 16'(kerr), 16'd0);
    check_eq("rst_ready", 16'(bus.TxDataReady), 16'd0);
    check_eq("rst_level", 16'(level), 16'd0);

    // Alignment preamble after reset release
    mon_en = 1'b1;
    rst_n = 1'b1;
    bad = 1'b0;
    for (int i = 1; i <= 15; i++) begin
      tick();
      if (i == 1) check_eq("t1_ready_first_edge", 16'(bus.TxDataReady), 16'd1);
      bad = bad | aligned | !out_k | (out_d != 8'hBC);
    end
    check_eq("t1_align_hold", 16'(bad), 16'd0);
    tick();
    check_eq("t1_aligned_at_16", 16'(aligned), 16'd1);
    check_eq("t1_bc_at_16", 16'({out_k, out_d}), 16'h1BC);
    repeat (3) tick();
    check_eq("t1_idle_comma", 16'({aligned, out_k, out_d}), 16'h3BC);

    // Minimum latency and level peak
    bus.TxDataValid = 1'b1;
    bus.TxDataKIn = 1'b0;
    bus.TxData = 8'h11;
    tick();
    exp_q.push_back({2'b00, 8'h11});
    check_eq("t2_level_a", 16'(level), 16'd1);
    bus.TxData = 8'h22;
    tick();
    check_eq("t2_out_11", 16'({out_k, out_d}), 16'h011);
    check_eq("t2_level_b", 16'(level), 16'd1);
    exp_q.push_back({2'b00, 8'h22});
    bus.TxData = 8'h33;
    tick();
    check_eq("t2_out_22", 16'({out_k, out_d}), 16'h022);
    exp_q.push_back({2'b00, 8'h33});
    bus.TxDataValid = 1'b0;
    tick();
    check_eq("t2_out_33", 16'({out_k, out_d}), 16'h033);
    check_eq("t2_level_end", 16'(level), 16'd0);
    tick();
    check_eq("t2_back_to_idle", 16'({out_k, out_d}), 16'h1BC);

    // Fill with TxEnable low, then drain in order
    en = 1'b0;
    for (int i = 0; i < 8; i++) push_word(1'b0, 8'(8'h40 + i));
    check_eq("t3_level_full", 16'(level), 16'd8);
    check_eq("t3_ready_full", 16'(bus.TxDataReady), 16'd0);
    bus.TxDataValid = 1'b1;
    bus.TxData = 8'h99;
    repeat (3) tick();
    check_eq("t3_ninth_held", 16'(level), 16'd8);
    bus.TxDataValid = 1'b0;
    en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      check_eq("t3_drain", 16'({out_k, out_d}), 16'(8'h40 + i));
      if (i == 0) check_eq("t3_ready_back", 16'(bus.TxDataReady), 16'd1);
    end
    tick();
    check_eq("t3_level_empty", 16'(level), 16'd0);

    // Legal and illegal K-chars
    push_word(1'b1, 8'h3C);
    push_word(1'b1, 8'hF7);
    check_eq("t5_legal_k", 16'({kerr, out_k, out_d}), 16'h13C);
    kcnt = 0;
    repeat (6) begin
      tick();
      if (kerr) kcnt++;
    end
    check_eq("t5_kerr_pulses", 16'(kcnt), 16'd1);

    // Reset in the middle of queued data
    en = 1'b0;
    for (int i = 0; i < 5; i++) push_word(1'b0, 8'(8'hA0 + i));
    check_eq("t6_level_5", 16'(level), 16'd5);
    rst_n = 1'b0;
    #1;
    check_eq("t6_rst_out", 16'({aligned, out_k, out_d}), 16'h1BC);
    check_eq("t6_rst_level", 16'(level), 16'd0);
    exp_q.delete();
    tick();
    rst_n = 1'b1;
    en = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 15; i++) begin
      tick();
      bad = bad | aligned;
    end
    check_eq("t6_realign_hold", 16'(bad), 16'd0);
    tick();
    check_eq("t6_aligned", 16'(aligned), 16'd1);
    repeat (10) tick();
    check_eq("t6_no_old_bytes", 16'(level), 16'd0);

    // Realign pulse in RUN keeps queued data
    en = 1'b0;
    for (int i = 0; i < 3; i++) push_word(1'b0, 8'(8'hC1 + i));
    realign = 1'b1;
    tick();
    realign = 1'b0;
    check_eq("t6_realign_drop", 16'(aligned), 16'd0);
    en = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 15; i++) begin
      tick();
      bad = bad | aligned | !out_k | (out_d != 8'hBC);
    end
    check_eq("t6_realign_commas", 16'(bad), 16'd0);
    tick();
    check_eq("t6_realign_run", 16'(aligned), 16'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("t6_resume", 16'({out_k, out_d}), 16'(8'hC1 + i));
    end
    tick();
    check_eq("t6_resume_level", 16'(level), 16'd0);
    check_eq("sb_drained", 16'(exp_q.size()), 16'd0);

    // Forced comma every 4 words on the short-period instance
    check_eq("t4_aligned", 16'(o4_al), 16'd1);
    for (int i = 0; i < 8; i++) push4(8'(8'h50 + i));
    check_eq("t4_level_full", 16'(o4_lv), 16'd8);
    en4 = 1'b1;
    fork
      begin
        push4(8'h58);
        push4(8'h59);
      end
      begin
        for (int i = 0; i < 13; i++) begin
          tick();
          cap4[i] = {o4_k, o4_d};
        end
      end
    join
    di = 0;
    for (int i = 0; i < 13; i++) begin
      if ((i % 4) == 3) begin
        check_eq("t4_forced_comma", 16'(cap4[i]), 16'h1BC);
      end else begin
        check_eq("t4_data", 16'(cap4[i]), 16'(8'h50 + di));
        di++;
      end
    end
    check_eq("t4_level_end", 16'(o4_lv), 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
